// File: rtl/dm_mc_pkg.sv
// Shared types for the multi-cycle data memory: access types and FSM states.
package dm_mc_pkg;

  // Access width / extension selector carried with every request.
  typedef enum logic [2:0] {
    MEM_W  = 3'd0,
    MEM_H  = 3'd1,
    MEM_HU = 3'd2,
    MEM_B  = 3'd3,
    MEM_BU = 3'd4
  } mem_type_e;

  // Controller states: memory clear walk, idle, wait states, response pulse.
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/dm_mc_lane.sv
// Byte-lane logic: merges store data into the old word and extracts/extends load data.
module dm_mc_lane
  import dm_mc_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  acc_type,
  input  logic [31:0] wdata,
  output logic [31:0] merged,
  output logic [31:0] rdata
);

  logic [15:0] ld_half;
  logic [7:0]  ld_byte;

  // Store merge and load extract; unsigned store types merge exactly like signed ones.
  always_comb begin
    merged  = old_word;
    rdata   = old_word;
    ld_half = byte_off[1] ? old_word[31:16] : old_word[15:0];
    ld_byte = old_word[{byte_off, 3'b000} +: 8];
    case (acc_type)
      MEM_W: begin
        merged = wdata;
        rdata  = old_word;
      end
      MEM_H, MEM_HU: begin
        if (byte_off[1]) merged[31:16] = wdata[15:0];
        else             merged[15:0]  = wdata[15:0];
        if (acc_type == MEM_H) rdata = {{16{ld_half[15]}}, ld_half};
        else                   rdata = {16'd0, ld_half};
      end
      MEM_B, MEM_BU: begin
        merged[{byte_off, 3'b000} +: 8] = wdata[7:0];
        if (acc_type == MEM_B) rdata = {{24{ld_byte[7]}}, ld_byte};
        else                   rdata = {24'd0, ld_byte};
      end
      default: begin
        merged = old_word;
        rdata  = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/dm_mc.sv
// Multi-cycle data memory for the MEM stage: valid/ready requests, wait states,
// sub-word accesses, exception reporting and an optional clear walk after reset.
module dm_mc
  import dm_mc_pkg::*;
#(
  parameter int ADDR_W         = 13,
  parameter int WAIT_CYC       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_exc,
  output logic        busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [CNT_W-1:0]  CNT_INIT    = CNT_W'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);
  localparam logic [ADDR_W-1:0] LAST_WORD   = ADDR_W'(DEPTH - 1);
  localparam state_e            RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  clr_q, clr_d;
  logic               exc_q, exc_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               we_q, we_d;
  logic [2:0]         type_q, type_d;
  logic [31:0]        addr_q, addr_d, wdata_q, wdata_d, pc_q, pc_d;
  logic [31:0]        mem_q [DEPTH];

  logic               cur_we;
  logic [2:0]         cur_type;
  logic [31:0]        cur_addr, cur_wdata, cur_pc;
  logic [31:0]        old_word, merged, ld_data;
  logic               req_exc, do_access, mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [31:0]        mem_wdata;

  // In IDLE the access (WAIT_CYC=0) uses the live request; later it uses the latched copy.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_we    = req_we;
      cur_type  = req_type;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_pc    = req_pc;
    end else begin
      cur_we    = we_q;
      cur_type  = type_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_pc    = pc_q;
    end
  end

  assign old_word = mem_q[cur_addr[ADDR_W+1:2]];

  dm_mc_lane u_lane (
    .old_word (old_word),
    .byte_off (cur_addr[1:0]),
    .acc_type (cur_type),
    .wdata    (cur_wdata),
    .merged   (merged),
    .rdata    (ld_data)
  );

  // Reject misaligned, out-of-range or unknown-type requests at accept time.
  always_comb begin
    req_exc = 1'b0;
    case (req_type)
      MEM_W:         req_exc = (req_addr[1:0] != 2'b00);
      MEM_H, MEM_HU: req_exc = req_addr[0];
      MEM_B, MEM_BU: req_exc = 1'b0;
      default:       req_exc = 1'b1;
    endcase
    if ((req_addr >> (ADDR_W + 2)) != 32'd0) req_exc = 1'b1;
  end

  // Next-state logic; the memory access happens on the edge that enters RESP.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr_d     = clr_q;
    exc_d     = exc_q;
    rdata_d   = 32'd0;
    we_d      = we_q;
    type_d    = type_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    pc_d      = pc_q;
    do_access = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = cur_addr[ADDR_W+1:2];
    mem_wdata = merged;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_q;
        mem_wdata = 32'd0;
        clr_d     = clr_q + 1'b1;
        if (clr_q == LAST_WORD) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          type_d  = req_type;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          pc_d    = req_pc;
          exc_d   = req_exc;
          cnt_d   = CNT_INIT;
          if (req_exc) begin
            state_d = ST_RESP;
          end else if (WAIT_CYC == 0) begin
            state_d   = ST_RESP;
            do_access = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d   = ST_RESP;
          do_access = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = RESET_STATE;
    endcase
    if (do_access) begin
      if (cur_we) mem_we  = 1'b1;
      else        rdata_d = ld_data;
    end
  end

  // Control state with synchronous reset; a reset mid-request drops it silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
      clr_q   <= '0;
      exc_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clr_q   <= clr_d;
      exc_q   <= exc_d;
      rdata_q <= rdata_d;
    end
  end

  // Latched request fields are plain data and need no reset.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    type_q  <= type_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    pc_q    <= pc_d;
  end

  // Storage array; writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem_q[mem_waddr] <= mem_wdata;
  end

`ifndef SYNTHESIS
  // Store trace for comparison against the reference simulator.
  always_ff @(posedge clk) begin
    if (!reset && do_access && cur_we)
      $display("%d@%h: *%h <= %h", $time, cur_pc, {cur_addr[31:2], 2'b00}, merged);
  end
`endif

  assign req_ready  = (state_q == ST_IDLE) && !reset;
  assign resp_valid = (state_q == ST_RESP) && !reset;
  assign resp_rdata = resp_valid ? rdata_q : 32'd0;
  assign resp_exc   = resp_valid && exc_q;
  assign busy       = reset || (state_q != ST_IDLE);

endmodule

// File: tb/tb_dm_mc.sv
// Directed bench for dm_mc: three instances cover WAIT_CYC = 1, 0 and 3.
module tb_dm_mc;
  import dm_mc_pkg::*;

  logic        clk;
  logic        reset      [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_we     [3];
  logic [2:0]  req_type   [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic [31:0] req_pc     [3];
  logic        resp_valid [3];
  logic [31:0] resp_rdata [3];
  logic        resp_exc   [3];
  logic        busy       [3];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dm_mc #(
      .ADDR_W         (4),
      .WAIT_CYC       ((g == 0) ? 1 : ((g == 1) ? 0 : 3)),
      .CLEAR_ON_RESET ((g == 1) ? 0 : 1)
    ) u_dut (
      .clk        (clk),
      .reset      (reset[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_we     (req_we[g]),
      .req_type   (req_type[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .req_pc     (req_pc[g]),
      .resp_valid (resp_valid[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_exc   (resp_exc[g]),
      .busy       (busy[g])
    );
  end

  // 10 ns clock plus a free-running cycle counter for accept spacing.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor for the back-to-back sequence on instance 1.
  bit          mon_en = 1'b0;
  int          npulse = 0;
  logic [31:0] prd [3];
  always @(negedge clk) begin
    if (mon_en && resp_valid[1]) begin
      if (npulse < 3) prd[npulse] = resp_rdata[1];
      npulse++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request on instance i and wait (bounded) for its response pulse.
  task automatic applyStimulus(input int i, input logic we, input logic [2:0] typ,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rd, output logic ex, output int lat);
    int n;
    @(negedge clk);
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_type[i]  = typ;
    req_addr[i]  = addr;
    req_wdata[i] = wdata;
    req_pc[i]    = 32'h0040_0000 + addr;
    n = 0;
    while (!req_ready[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_ready", {31'd0, req_ready[i]}, 32'd1);
    @(negedge clk);
    req_valid[i] = 1'b0;
    lat = 1;
    while (!resp_valid[i] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("resp_seen", {31'd0, resp_valid[i]}, 32'd1);
    rd = resp_rdata[i];
    ex = resp_exc[i];
    @(negedge clk);
    checkOutput("pulse_width", {31'd0, resp_valid[i]}, 32'd0);
  endtask

  task automatic run(input string tag, input int i, input logic we, input logic [2:0] typ,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input logic exp_ex, input int exp_lat);
    logic [31:0] rd;
    logic        ex;
    int          lat;
    applyStimulus(i, we, typ, addr, wdata, rd, ex, lat);
    checkOutput({tag, "_rdata"}, rd, exp_rd);
    checkOutput({tag, "_exc"}, {31'd0, ex}, {31'd0, exp_ex});
    checkOutput({tag, "_lat"}, lat, exp_lat);
  endtask

  initial begin
    int n;
    bit seen;
    int acc [3];
    for (int i = 0; i < 3; i++) begin
      reset[i]     = 1'b1;
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      req_type[i]  = MEM_W;
      req_addr[i]  = 32'd0;
      req_wdata[i] = 32'd0;
      req_pc[i]    = 32'd0;
    end
    repeat (3) @(negedge clk);

    // Output values while reset is held.
    checkOutput("rst_ready", {31'd0, req_ready[0]}, 32'd0);
    checkOutput("rst_valid", {31'd0, resp_valid[0]}, 32'd0);
    checkOutput("rst_rdata", resp_rdata[0], 32'd0);
    checkOutput("rst_exc", {31'd0, resp_exc[0]}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy[0]}, 32'd1);

    for (int i = 0; i < 3; i++) reset[i] = 1'b0;
    #1;
    checkOutput("noclear_ready", {31'd0, req_ready[1]}, 32'd1);
    checkOutput("noclear_busy", {31'd0, busy[1]}, 32'd0);
    checkOutput("clear_busy", {31'd0, busy[0]}, 32'd1);
    n = 0;
    while (!req_ready[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("clear_cycles", n, 16);
    checkOutput("idle_busy", {31'd0, busy[0]}, 32'd0);

    // Cleared memory, word round trip, sub-word accesses (instance 0, WAIT_CYC=1).
    run("lw_cleared", 0, 1'b0, MEM_W,  32'h3C, 32'h0,         32'h0,         1'b0, 2);
    run("sw_word",    0, 1'b1, MEM_W,  32'h10, 32'h12345678,  32'h0,         1'b0, 2);
    run("lw_word",    0, 1'b0, MEM_W,  32'h10, 32'h0,         32'h12345678,  1'b0, 2);
    run("sw_base",    0, 1'b1, MEM_W,  32'h20, 32'h80000000,  32'h0,         1'b0, 2);
    run("sb_21",      0, 1'b1, MEM_B,  32'h21, 32'hFFFFFFAB,  32'h0,         1'b0, 2);
    run("lw_merged",  0, 1'b0, MEM_W,  32'h20, 32'h0,         32'h8000AB00,  1'b0, 2);
    run("lb_21",      0, 1'b0, MEM_B,  32'h21, 32'h0,         32'hFFFFFFAB,  1'b0, 2);
    run("lbu_21",     0, 1'b0, MEM_BU, 32'h21, 32'h0,         32'h000000AB,  1'b0, 2);
    run("lh_22",      0, 1'b0, MEM_H,  32'h22, 32'h0,         32'hFFFF8000,  1'b0, 2);
    run("lhu_22",     0, 1'b0, MEM_HU, 32'h22, 32'h0,         32'h00008000,  1'b0, 2);
    run("lh_20",      0, 1'b0, MEM_H,  32'h20, 32'h0,         32'hFFFFAB00,  1'b0, 2);
    run("lb_23",      0, 1'b0, MEM_B,  32'h23, 32'h0,         32'hFFFFFF80,  1'b0, 2);
    run("lbu_20",     0, 1'b0, MEM_BU, 32'h20, 32'h0,         32'h00000000,  1'b0, 2);

    // Exceptions respond one cycle after accept with rdata forced to 0.
    run("lw_misal",   0, 1'b0, MEM_W,  32'h22, 32'h0,         32'h0,         1'b1, 1);
    run("sh_misal",   0, 1'b1, MEM_H,  32'h23, 32'h5555,      32'h0,         1'b1, 1);
    run("lw_after",   0, 1'b0, MEM_W,  32'h20, 32'h0,         32'h8000AB00,  1'b0, 2);
    run("lw_range",   0, 1'b0, MEM_W,  32'h40, 32'h0,         32'h0,         1'b1, 1);
    run("type5",      0, 1'b0, 3'd5,   32'h0,  32'h0,         32'h0,         1'b1, 1);

    // Back-to-back on instance 1 (WAIT_CYC=0) with req_valid held throughout.
    @(negedge clk);
    mon_en = 1'b1;
    req_valid[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_we[1]    = (k != 2);
      req_type[1]  = MEM_W;
      req_addr[1]  = (k == 1) ? 32'h4 : 32'h0;
      req_wdata[1] = (k == 0) ? 32'hCAFEF00D : 32'h0BADBEEF;
      req_pc[1]    = 32'h0040_0100 + 32'(k * 4);
      n = 0;
      while (!req_ready[1] && n < 20) begin
        @(negedge clk);
        n++;
      end
      acc[k] = cyc;
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    checkOutput("b2b_gap01", acc[1] - acc[0], 2);
    checkOutput("b2b_gap12", acc[2] - acc[1], 2);
    checkOutput("b2b_pulses", npulse, 3);
    checkOutput("b2b_rd0", prd[0], 32'h0);
    checkOutput("b2b_rd1", prd[1], 32'h0);
    checkOutput("b2b_rd2", prd[2], 32'hCAFEF00D);
    run("b2b_lw4", 1, 1'b0, MEM_W, 32'h4, 32'h0, 32'h0BADBEEF, 1'b0, 1);

    // Reset during WAIT on instance 2 (WAIT_CYC=3): no response, clear restarts.
    run("w3_sw", 2, 1'b1, MEM_W, 32'h8, 32'h11223344, 32'h0, 1'b0, 4);
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b1;
    req_type[2]  = MEM_W;
    req_addr[2]  = 32'h8;
    req_wdata[2] = 32'hFFFFFFFF;
    req_pc[2]    = 32'h0040_0200;
    n = 0;
    while (!req_ready[2] && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid[2] = 1'b0;
    reset[2]     = 1'b1;
    seen = (resp_valid[2] === 1'b1);
    @(negedge clk);
    reset[2] = 1'b0;
    #1;
    n = 0;
    while (!req_ready[2] && n < 100) begin
      if (resp_valid[2] !== 1'b0) seen = 1'b1;
      @(negedge clk);
      n++;
    end
    checkOutput("midrst_noresp", {31'd0, seen}, 32'd0);
    checkOutput("midrst_clear", n, 16);
    run("midrst_lw", 2, 1'b0, MEM_W, 32'h8, 32'h0, 32'h0, 1'b0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
